if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the pc_4 field.
REQ-002 SHALL have parameter INST_W, default 32, width of the instruction field.
REQ-003 SHALL have parameter DEPTH, default 4, skid-FIFO entries; legal values are powers of two, 2..16.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cpu_en  in  1  global enable; 0 freezes all state except exceptClear.
REQ-007 SHALL have port exceptClear  in  1  synchronous clear from CP0.
REQ-008 SHALL have port id_shouldStall  in  1  ID cannot accept a new instruction this cycle.
REQ-009 SHALL have port id_shouldJumpOrBranch  in  1  redirect; flush wrong-path contents.
REQ-010 SHALL have port if_valid  in  1  IF presents a fetched instruction.
REQ-011 SHALL have port if_pc_4  in  ADDR_W  PC+4 of the fetched instruction.
REQ-012 SHALL have port if_instruction  in  INST_W  fetched instruction word.
REQ-013 SHALL have port if_ready  out  1  combinational; 1 when an IF beat is accepted this cycle.
REQ-014 SHALL have port id_valid  out  1  registered; ID output holds a real instruction.
REQ-015 SHALL have port id_pc_4  out  ADDR_W  registered PC+4 for ID.
REQ-016 SHALL have port id_instruction  out  INST_W  registered instruction for ID; 0 is a bubble.
REQ-017 SHALL have port fifo_count  out  $clog2(DEPTH+1)  current skid-FIFO occupancy.

Function
REQ-018 SHALL consist of one output register (id_*) fed by a DEPTH-entry circular FIFO of {pc_4, instruction}, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 SHALL define an "advance" cycle as cpu_en=1, exceptClear=0, id_shouldStall=0.
REQ-020 SHALL drive if_ready=1 iff cpu_en=1, exceptClear=0, flush not in effect, and either fifo_count<DEPTH or (advance and fifo_count>0).
REQ-021 SHALL accept an IF beat only when if_valid=1 and if_ready=1 in the same cycle.
REQ-022 SHALL, on an advance cycle with fifo_count>0, load the FIFO head into id_* with id_valid=1 and pop the head.
REQ-023 SHALL, on an advance cycle with fifo_count=0 and an accepted beat, load the beat directly into id_* (1-cycle latency) without touching the FIFO.
REQ-024 SHALL, on an advance cycle with fifo_count=0 and no accepted beat, load a bubble: id_instruction=0, id_pc_4=0, id_valid=0.
REQ-025 SHALL, on an advance cycle with fifo_count>0 and an accepted beat, pop and push in the same cycle so that fifo_count is unchanged.
REQ-026 SHALL, when cpu_en=1, exceptClear=0 and id_shouldStall=1, hold id_* unchanged and push an accepted beat into the FIFO.
REQ-027 SHALL, when full and stalled, deassert if_ready and leave all state unchanged.
REQ-028 SHALL treat id_shouldJumpOrBranch=1 on an advance cycle as a flush: id_* takes a bubble, the FIFO empties (pointers=0, count=0), and the IF beat is dropped (if_ready=0).
REQ-029 SHALL ignore id_shouldJumpOrBranch while id_shouldStall=1.
REQ-030 SHALL, when exceptClear=1, clear id_*, id_valid, pointers and count on that edge regardless of cpu_en, stall or flush, and hold if_ready=0.
REQ-031 SHALL, when cpu_en=0 and exceptClear=0, hold all registers and drive if_ready=0.
REQ-032 SHALL never let fifo_count exceed DEPTH or underflow below 0.
REQ-033 SHALL use the priority order rst > exceptClear > cpu_en=0 > stall > flush > normal.

Reset
REQ-034 SHALL, on rst=1, asynchronously clear id_pc_4, id_instruction, id_valid, the pointers and fifo_count to 0; FIFO storage need not be cleared.
REQ-035 SHALL, on rst assertion mid-operation, discard all queued entries, and SHALL emit the first output in the first cycle after deassertion.

Verification
REQ-036 SHALL pass this scenario: with no stall, beats A(pc 0x4), B(pc 0x8) on consecutive cycles -> id_* shows A then B one cycle after each; fifo_count stays 0.
REQ-037 SHALL pass this scenario: stall for 6 cycles with if_valid=1 at DEPTH=4 -> fifo_count reaches 4, then if_ready=0; after release, the 4 entries drain in order, one per cycle.
REQ-038 SHALL pass this scenario: fifo_count=3 with push and pop in the same advance cycle -> fifo_count remains 3 and FIFO order is preserved across pointer wrap.
REQ-039 SHALL pass this scenario: fifo_count=2 and id_shouldJumpOrBranch=1 with no stall -> next cycle id_instruction=0, id_valid=0, fifo_count=0, and the concurrent IF beat is absent from later output.
REQ-040 SHALL pass this scenario: exceptClear=1 with cpu_en=0 and fifo_count=3 -> all outputs and fifo_count are 0 after the edge.
REQ-041 SHALL pass this scenario: rst pulse asserted between clock edges while the FIFO is full -> outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// IF->ID pipeline register backed by a small skid FIFO, so IF keeps fetching
// while ID stalls. Entries drain in fetch order; redirects and CP0 clears flush.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_en,
  input  logic                         exceptClear,
  input  logic                         id_shouldStall,
  input  logic                         id_shouldJumpOrBranch,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc_4,
  input  logic [INST_W-1:0]            if_instruction,
  output logic                         if_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc_4,
  output logic [INST_W-1:0]            id_instruction,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc_4;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            advance, flush, empty, full, accept, push, pop;

  assign advance  = cpu_en & ~exceptClear & ~id_shouldStall;
  assign flush    = advance & id_shouldJumpOrBranch;
  assign empty    = (fifo_count == '0);
  assign full     = (fifo_count == FULL);
  assign if_ready = cpu_en & ~exceptClear & ~flush & (~full | (advance & ~empty));
  assign accept   = if_valid & if_ready;
  // An accepted beat bypasses the FIFO only when ID advances from an empty queue.
  assign push     = accept & (id_shouldStall | ~empty);
  assign pop      = advance & ~flush & ~empty;

  // Storage carries no reset; occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc_4: if_pc_4, inst: if_instruction};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_count     <= '0;
      id_valid       <= 1'b0;
      id_pc_4        <= '0;
      id_instruction <= '0;
    end else if (exceptClear) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_count     <= '0;
      id_valid       <= 1'b0;
      id_pc_4        <= '0;
      id_instruction <= '0;
    end else if (cpu_en) begin
      if (flush) begin
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        fifo_count     <= '0;
        id_valid       <= 1'b0;
        id_pc_4        <= '0;
        id_instruction <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
        if (advance) begin
          if (!empty) begin
            id_valid       <= 1'b1;
            id_pc_4        <= mem[rd_ptr].pc_4;
            id_instruction <= mem[rd_ptr].inst;
          end else if (accept) begin
            id_valid       <= 1'b1;
            id_pc_4        <= if_pc_4;
            id_instruction <= if_instruction;
          end else begin
            id_valid       <= 1'b0;
            id_pc_4        <= '0;
            id_instruction <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a queue scoreboard holds fetched beats in
// order; each ID load pops the head and the remaining depth is the FIFO count.
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk, rst, cpu_en, exceptClear, id_shouldStall, id_shouldJumpOrBranch, if_valid;
  logic [31:0] if_pc_4, if_instruction;
  logic        if_ready, id_valid;
  logic [31:0] id_pc_4, id_instruction;
  logic [2:0]  fifo_count;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .exceptClear(exceptClear),
    .id_shouldStall(id_shouldStall), .id_shouldJumpOrBranch(id_shouldJumpOrBranch),
    .if_valid(if_valid), .if_pc_4(if_pc_4), .if_instruction(if_instruction),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc_4(id_pc_4),
    .id_instruction(id_instruction), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          nxt   = 1;
  logic [63:0] sb [$];
  logic        e_v;
  logic [31:0] e_pc, e_ins;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".id_valid"}, id_valid, e_v);
    chk({tag, ".id_pc_4"}, id_pc_4, e_pc);
    chk({tag, ".id_inst"}, id_instruction, e_ins);
    chk({tag, ".count"}, fifo_count, sb.size());
  endtask

  task automatic bubble();
    e_v = 1'b0; e_pc = '0; e_ins = '0;
  endtask

  // One clock: drive inputs, check if_ready, take the edge, update scoreboard, check outputs.
  task automatic step(input string tag, input logic en, exc, st, jmp, v);
    logic        adv, fl, rdy_e, acc;
    logic [63:0] beat, hd;
    int          sz;
    cpu_en = en; exceptClear = exc; id_shouldStall = st;
    id_shouldJumpOrBranch = jmp; if_valid = v;
    if_pc_4 = nxt << 2; if_instruction = 32'h1000_0000 + nxt;
    beat = {if_pc_4, if_instruction};
    #1;
    sz    = sb.size();
    adv   = en & ~exc & ~st;
    fl    = adv & jmp;
    rdy_e = en & ~exc & ~fl & ((sz < DEPTH) | (adv & (sz > 0)));
    acc   = v & rdy_e;
    chk({tag, ".if_ready"}, if_ready, rdy_e);
    @(posedge clk); #1;
    if (exc) begin
      sb.delete(); bubble();
    end else if (en) begin
      if (acc) sb.push_back(beat);
      if (adv) begin
        if (fl) begin
          sb.delete(); bubble();
        end else if (sb.size() > 0) begin
          hd = sb.pop_front();
          e_v = 1'b1; e_pc = hd[63:32]; e_ins = hd[31:0];
        end else bubble();
      end
    end
    if (acc) nxt++;
    chk_out(tag);
  endtask

  initial begin
    rst = 1'b1; cpu_en = 0; exceptClear = 0; id_shouldStall = 0;
    id_shouldJumpOrBranch = 0; if_valid = 0; if_pc_4 = '0; if_instruction = '0;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset");
    chk("reset.if_ready", if_ready, 1'b0);
    rst = 1'b0;

    // Straight-through: A then B, one cycle latency, FIFO untouched.
    step("pass_a", 1, 0, 0, 0, 1);
    chk("pass_a.pc", id_pc_4, 32'h4);
    step("pass_b", 1, 0, 0, 0, 1);
    chk("pass_b.pc", id_pc_4, 32'h8);
    chk("pass_b.count", fifo_count, 3'd0);
    step("idle", 1, 0, 0, 0, 0);

    // Stall with continuous fetch: fill to DEPTH, then back-pressure.
    step("fill0", 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step("stall", 1, 0, 1, 0, 1);
    chk("stall.full", fifo_count, 3'd4);
    #1 chk("stall.rdy_low", if_ready, 1'b0);
    for (int i = 0; i < 5; i++) step("drain", 1, 0, 0, 0, 0);
    chk("drain.empty", fifo_count, 3'd0);

    // Hold depth 3 with simultaneous push/pop across pointer wrap.
    step("w_load", 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("w_fill", 1, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step("w_pp", 1, 0, 0, 0, 1);
    chk("w_pp.count3", fifo_count, 3'd3);
    for (int i = 0; i < 4; i++) step("w_drain", 1, 0, 0, 0, 0);

    // Redirect with two queued entries and a concurrent beat.
    step("f_load", 1, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step("f_fill", 1, 0, 1, 0, 1);
    step("flush", 1, 0, 0, 1, 1);
    chk("flush.inst0", id_instruction, 32'h0);
    step("f_after0", 1, 0, 0, 0, 0);
    step("f_after1", 1, 0, 0, 0, 1);

    // Jump while stalled is ignored.
    for (int i = 0; i < 2; i++) step("js_fill", 1, 0, 1, 0, 1);
    step("js_jump", 1, 0, 1, 1, 1);
    chk("js_jump.count", fifo_count, 3'd3);

    // cpu_en=0 freezes everything.
    step("frz0", 0, 0, 0, 0, 1);
    step("frz1", 0, 0, 0, 1, 1);

    // exceptClear while disabled with three queued entries.
    step("exc", 0, 1, 1, 1, 1);
    chk("exc.count0", fifo_count, 3'd0);
    chk("exc.valid0", id_valid, 1'b0);
    step("exc_after", 1, 0, 0, 0, 1);

    // Fill to full, then asynchronous reset between edges.
    for (int i = 0; i < 4; i++) step("r_fill", 1, 0, 1, 0, 1);
    chk("r_fill.full", fifo_count, 3'd4);
    rst = 1'b1;
    #2;
    sb.delete(); bubble();
    chk_out("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst", 1, 0, 0, 0, 1);
    chk("post_rst.valid", id_valid, 1'b1);
    step("post_rst_idle", 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
